// File: rtl/latch_bus_monitor.sv
// Latch-strobe cube bus monitor: captures column bytes on latch strobes, commits
// them into an 8x8 frame image on layer enables, and flags bus protocol errors.
module latch_bus_monitor #(
    parameter int ON_CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7:0]          data_in,
    input  logic [7:0]          latch_in,
    input  logic [7:0]          layer_in,
    input  logic [2:0]          rd_layer,
    input  logic [2:0]          rd_latch,
    output logic [7:0]          rd_data,
    input  logic                err_clr,
    output logic                layer_commit,
    output logic [2:0]          layer_idx,
    output logic                frame_done,
    output logic [ON_CNT_W-1:0] on_time,
    output logic                err_latch,
    output logic                err_layer,
    output logic                err_overlap
);

    localparam logic [ON_CNT_W-1:0] CNT_MAX  = {ON_CNT_W{1'b1}};
    localparam logic [ON_CNT_W-1:0] CNT_ZERO = {ON_CNT_W{1'b0}};
    localparam logic [ON_CNT_W-1:0] CNT_ONE  = {{(ON_CNT_W-1){1'b0}}, 1'b1};

    function automatic logic multi_hot(input logic [7:0] v);
        return (v & (v - 8'd1)) != 8'd0;
    endfunction

    function automatic logic [2:0] lowest_set(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

    logic [7:0]          r_latch_q;
    logic [7:0]          r_layer_q;
    logic [7:0]          r_shadow [8];
    logic [7:0]          r_shadow_mask;
    logic [7:0]          r_done_mask;
    logic [7:0]          r_frame [64];
    logic [ON_CNT_W-1:0] r_cnt;
    logic [ON_CNT_W-1:0] r_on_time;
    logic [2:0]          r_layer_idx;
    logic [7:0]          r_rd_data;
    logic                r_layer_commit;
    logic                r_frame_done;
    logic                r_err_latch;
    logic                r_err_layer;
    logic                r_err_overlap;

    logic [7:0] w_latch_rise;
    logic       w_layer_rise;
    logic       w_layer_fall;
    logic       w_layer_jump;
    logic [2:0] w_commit_idx;
    logic [7:0] w_commit_bit;
    logic [7:0] w_done_acc;
    logic       w_frame_full;
    logic [7:0] w_shadow_mask_nxt;
    logic       w_set_err_latch;
    logic       w_set_err_layer;
    logic       w_set_err_overlap;

    // Edge detection, commit decode and error conditions for this cycle
    always_comb begin
        w_latch_rise      = latch_in & ~r_latch_q;
        w_layer_rise      = (r_layer_q == 8'h00) && (layer_in != 8'h00);
        w_layer_fall      = (r_layer_q != 8'h00) && (layer_in == 8'h00);
        w_layer_jump      = (r_layer_q != 8'h00) && (layer_in != 8'h00) && (layer_in != r_layer_q);
        w_commit_idx      = lowest_set(layer_in);
        w_commit_bit      = 8'h01 << w_commit_idx;
        w_done_acc        = r_done_mask;
        w_shadow_mask_nxt = r_shadow_mask | w_latch_rise;
        if (w_layer_rise) begin
            w_done_acc        = r_done_mask | w_commit_bit;
            w_shadow_mask_nxt = w_latch_rise;
        end else begin
            w_done_acc        = r_done_mask;
            w_shadow_mask_nxt = r_shadow_mask | w_latch_rise;
        end
        w_frame_full      = w_layer_rise && (w_done_acc == 8'hFF);
        w_set_err_latch   = multi_hot(w_latch_rise);
        w_set_err_layer   = (w_layer_rise && multi_hot(layer_in)) || w_layer_jump;
        w_set_err_overlap = (w_latch_rise != 8'h00) && (layer_in != 8'h00);
    end

    // Input history and column shadow registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_latch_q     <= 8'h00;
            r_layer_q     <= 8'h00;
            r_shadow_mask <= 8'h00;
            for (int k = 0; k < 8; k++) begin
                r_shadow[k] <= 8'h00;
            end
        end else begin
            r_latch_q     <= latch_in;
            r_layer_q     <= layer_in;
            r_shadow_mask <= w_shadow_mask_nxt;
            for (int k = 0; k < 8; k++) begin
                if (w_latch_rise[k]) begin
                    r_shadow[k] <= data_in;
                end
            end
        end
    end

    // Frame image: a commit copies the pre-edge shadow, so a capture in the
    // same cycle lands in the freshly cleared shadow instead
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 64; i++) begin
                r_frame[i] <= 8'h00;
            end
        end else if (w_layer_rise) begin
            for (int k = 0; k < 8; k++) begin
                if (r_shadow_mask[k]) begin
                    r_frame[{w_commit_idx, 3'(k)}] <= r_shadow[k];
                end
            end
        end
    end

    // Registered frame read port (returns pre-commit contents on collision)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data <= 8'h00;
        end else begin
            r_rd_data <= r_frame[{rd_layer, rd_latch}];
        end
    end

    // Commit status, frame completion tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_layer_commit <= 1'b0;
            r_frame_done   <= 1'b0;
            r_layer_idx    <= 3'd0;
            r_done_mask    <= 8'h00;
        end else begin
            r_layer_commit <= w_layer_rise;
            r_frame_done   <= w_frame_full;
            if (w_layer_rise) begin
                r_layer_idx <= w_commit_idx;
            end
            if (w_frame_full) begin
                r_done_mask <= 8'h00;
            end else begin
                r_done_mask <= w_done_acc;
            end
        end
    end

    // Layer on-time counter, saturating, latched on the falling edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= CNT_ZERO;
            r_on_time <= CNT_ZERO;
        end else if (w_layer_fall) begin
            r_on_time <= r_cnt;
            r_cnt     <= CNT_ZERO;
        end else if ((layer_in != 8'h00) && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + CNT_ONE;
        end
    end

    // Sticky error flags; a new error wins over a same-cycle clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_latch   <= 1'b0;
            r_err_layer   <= 1'b0;
            r_err_overlap <= 1'b0;
        end else begin
            r_err_latch   <= w_set_err_latch   | (r_err_latch   & ~err_clr);
            r_err_layer   <= w_set_err_layer   | (r_err_layer   & ~err_clr);
            r_err_overlap <= w_set_err_overlap | (r_err_overlap & ~err_clr);
        end
    end

    assign rd_data      = r_rd_data;
    assign layer_commit = r_layer_commit;
    assign layer_idx    = r_layer_idx;
    assign frame_done   = r_frame_done;
    assign on_time      = r_on_time;
    assign err_latch    = r_err_latch;
    assign err_layer    = r_err_layer;
    assign err_overlap  = r_err_overlap;

endmodule

// File: tb/tb_latch_bus_monitor.sv
// Bench for latch_bus_monitor: table vectors, directed sequences and random
// traffic, all checked against a frame-level reference model.
module tb_latch_bus_monitor;

    localparam int CW = 4;
    localparam logic [CW-1:0] CMAX = {CW{1'b1}};

    logic          clk;
    logic          rst_n;
    logic [7:0]    data_in;
    logic [7:0]    latch_in;
    logic [7:0]    layer_in;
    logic [2:0]    rd_layer;
    logic [2:0]    rd_latch;
    logic [7:0]    rd_data;
    logic          err_clr;
    logic          layer_commit;
    logic [2:0]    layer_idx;
    logic          frame_done;
    logic [CW-1:0] on_time;
    logic          err_latch;
    logic          err_layer;
    logic          err_overlap;

    latch_bus_monitor #(.ON_CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .latch_in(latch_in),
        .layer_in(layer_in), .rd_layer(rd_layer), .rd_latch(rd_latch),
        .rd_data(rd_data), .err_clr(err_clr), .layer_commit(layer_commit),
        .layer_idx(layer_idx), .frame_done(frame_done), .on_time(on_time),
        .err_latch(err_latch), .err_layer(err_layer), .err_overlap(err_overlap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [7:0]    m_frame [8][8];
    logic [7:0]    m_shadow [8];
    bit            m_held [8];
    bit            m_done [8];
    logic [7:0]    m_prev_latch, m_prev_layer;
    int            m_cnt;
    logic [CW-1:0] m_on;
    logic          m_commit, m_fdone, m_el, m_ey, m_eo;
    logic [2:0]    m_idx;
    logic [7:0]    m_rd;

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int l = 0; l < 8; l++) begin
            for (int c = 0; c < 8; c++) m_frame[l][c] = 8'h00;
            m_shadow[l] = 8'h00;
            m_held[l]   = 1'b0;
            m_done[l]   = 1'b0;
        end
        m_prev_latch = 8'h00; m_prev_layer = 8'h00;
        m_cnt = 0; m_on = '0;
        m_commit = 1'b0; m_fdone = 1'b0; m_idx = 3'd0; m_rd = 8'h00;
        m_el = 1'b0; m_ey = 1'b0; m_eo = 1'b0;
    endtask

    task automatic model_step(input logic [7:0] d, input logic [7:0] lt, input logic [7:0] ly,
                              input logic [2:0] rl, input logic [2:0] rk, input logic ec);
        int  n_rise, j, n_done;
        bit  lrise, lfall, jump, new_el, new_ey, new_eo;
        lrise  = (m_prev_layer == 8'h00) && (ly != 8'h00);
        lfall  = (m_prev_layer != 8'h00) && (ly == 8'h00);
        jump   = (m_prev_layer != 8'h00) && (ly != 8'h00) && (ly != m_prev_layer);
        n_rise = 0;
        for (int k = 0; k < 8; k++) if (lt[k] && !m_prev_latch[k]) n_rise++;
        m_rd     = m_frame[rl][rk];
        m_commit = lrise;
        m_fdone  = 1'b0;
        if (lrise) begin
            j = 0;
            while (ly[j] == 1'b0) j++;
            for (int k = 0; k < 8; k++) begin
                if (m_held[k]) m_frame[j][k] = m_shadow[k];
                m_held[k] = 1'b0;
            end
            m_done[j] = 1'b1;
            m_idx = 3'(j);
            n_done = 0;
            for (int l = 0; l < 8; l++) if (m_done[l]) n_done++;
            if (n_done == 8) begin
                m_fdone = 1'b1;
                for (int l = 0; l < 8; l++) m_done[l] = 1'b0;
            end
        end
        for (int k = 0; k < 8; k++) begin
            if (lt[k] && !m_prev_latch[k]) begin
                m_shadow[k] = d;
                m_held[k]   = 1'b1;
            end
        end
        new_el = n_rise > 1;
        new_ey = (lrise && $countones(ly) != 1) || jump;
        new_eo = (n_rise > 0) && (ly != 8'h00);
        m_el = new_el || (m_el && !ec);
        m_ey = new_ey || (m_ey && !ec);
        m_eo = new_eo || (m_eo && !ec);
        if (lfall) begin
            m_on  = CW'(m_cnt);
            m_cnt = 0;
        end else if (ly != 8'h00 && m_cnt < int'(CMAX)) begin
            m_cnt++;
        end
        m_prev_latch = lt;
        m_prev_layer = ly;
    endtask

    task automatic check_all(input string tag);
        check({tag, "_commit"}, {15'd0, layer_commit}, {15'd0, m_commit});
        check({tag, "_idx"}, {13'd0, layer_idx}, {13'd0, m_idx});
        check({tag, "_fdone"}, {15'd0, frame_done}, {15'd0, m_fdone});
        check({tag, "_ontime"}, 16'(on_time), 16'(m_on));
        check({tag, "_elatch"}, {15'd0, err_latch}, {15'd0, m_el});
        check({tag, "_elayer"}, {15'd0, err_layer}, {15'd0, m_ey});
        check({tag, "_eoverlap"}, {15'd0, err_overlap}, {15'd0, m_eo});
        check({tag, "_rd"}, {8'd0, rd_data}, {8'd0, m_rd});
    endtask

    task automatic step(input logic [7:0] d, input logic [7:0] lt, input logic [7:0] ly,
                        input logic [2:0] rl, input logic [2:0] rk, input logic ec);
        data_in = d; latch_in = lt; layer_in = ly;
        rd_layer = rl; rd_latch = rk; err_clr = ec;
        @(posedge clk);
        #1;
        model_step(d, lt, ly, rl, rk, ec);
        check_all("model");
    endtask

    // Asynchronous reset: outputs must clear before any clock edge
    task automatic do_reset();
        data_in = 8'h00; latch_in = 8'h00; layer_in = 8'h00;
        rd_layer = 3'd0; rd_latch = 3'd0; err_clr = 1'b0;
        rst_n = 1'b0;
        #2;
        model_reset();
        check("rst_rd", {8'd0, rd_data}, 16'h0000);
        check("rst_commit", {15'd0, layer_commit}, 16'h0000);
        check("rst_idx", {13'd0, layer_idx}, 16'h0000);
        check("rst_fdone", {15'd0, frame_done}, 16'h0000);
        check("rst_ontime", 16'(on_time), 16'h0000);
        check("rst_errs", {13'd0, err_latch, err_layer, err_overlap}, 16'h0000);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [7:0] d, lt, ly;
        logic [2:0] rl, rk;
        logic       ec;
        logic       commit;
        logic [2:0] idx;
        logic       el, ey, eo;
        logic [7:0] rd;
    } vec_t;

    vec_t       tbl [15];
    logic [7:0] dat [8];
    logic [7:0] ly_r, lt_r;
    int         r;

    initial begin
        // d, lt, ly, rl, rk, ec | commit, idx, el, ey, eo, rd
        tbl[0]  = '{8'h00, 8'h00, 8'h00, 3'd1, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[1]  = '{8'hA5, 8'h03, 8'h00, 3'd1, 3'd0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 8'h00};
        tbl[2]  = '{8'h00, 8'h00, 8'h00, 3'd1, 3'd1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[3]  = '{8'h00, 8'h00, 8'h06, 3'd1, 3'd0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b1, 1'b0, 8'h00};
        tbl[4]  = '{8'h00, 8'h00, 8'h00, 3'd1, 3'd0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b1, 1'b0, 8'hA5};
        tbl[5]  = '{8'h00, 8'h00, 8'h02, 3'd1, 3'd1, 1'b0, 1'b1, 3'd1, 1'b0, 1'b1, 1'b0, 8'hA5};
        tbl[6]  = '{8'h00, 8'h00, 8'h04, 3'd1, 3'd1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b1, 1'b0, 8'hA5};
        tbl[7]  = '{8'h00, 8'h00, 8'h00, 3'd0, 3'd0, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[8]  = '{8'h00, 8'h00, 8'h10, 3'd4, 3'd4, 1'b0, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[9]  = '{8'h3C, 8'h10, 8'h10, 3'd4, 3'd4, 1'b0, 1'b0, 3'd4, 1'b0, 1'b0, 1'b1, 8'h00};
        tbl[10] = '{8'h00, 8'h00, 8'h00, 3'd5, 3'd4, 1'b0, 1'b0, 3'd4, 1'b0, 1'b0, 1'b1, 8'h00};
        tbl[11] = '{8'h00, 8'h00, 8'h20, 3'd5, 3'd4, 1'b0, 1'b1, 3'd5, 1'b0, 1'b0, 1'b1, 8'h00};
        tbl[12] = '{8'h00, 8'h00, 8'h00, 3'd5, 3'd4, 1'b1, 1'b0, 3'd5, 1'b0, 1'b0, 1'b0, 8'h3C};
        tbl[13] = '{8'h11, 8'hC0, 8'h00, 3'd5, 3'd4, 1'b1, 1'b0, 3'd5, 1'b1, 1'b0, 1'b0, 8'h3C};
        tbl[14] = '{8'h00, 8'h00, 8'h00, 3'd5, 3'd4, 1'b1, 1'b0, 3'd5, 1'b0, 1'b0, 1'b0, 8'h3C};
        dat = '{8'h81, 8'h42, 8'h24, 8'h18, 8'h18, 8'h24, 8'h42, 8'h81};

        do_reset();

        for (int i = 0; i < 15; i++) begin
            step(tbl[i].d, tbl[i].lt, tbl[i].ly, tbl[i].rl, tbl[i].rk, tbl[i].ec);
            check($sformatf("tbl%0d_commit", i), {15'd0, layer_commit}, {15'd0, tbl[i].commit});
            check($sformatf("tbl%0d_idx", i), {13'd0, layer_idx}, {13'd0, tbl[i].idx});
            check($sformatf("tbl%0d_errs", i), {13'd0, err_latch, err_layer, err_overlap},
                  {13'd0, tbl[i].el, tbl[i].ey, tbl[i].eo});
            check($sformatf("tbl%0d_rd", i), {8'd0, rd_data}, {8'd0, tbl[i].rd});
        end

        // Single column capture, layer 0 on for 10 cycles
        do_reset();
        step(8'h81, 8'h80, 8'h00, 3'd0, 3'd7, 1'b0);
        step(8'h81, 8'h00, 8'h00, 3'd0, 3'd7, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(8'h00, 8'h00, 8'h01, 3'd0, 3'd7, 1'b0);
            if (i == 0) begin
                check("l0_commit", {15'd0, layer_commit}, 16'h0001);
                check("l0_idx", {13'd0, layer_idx}, 16'h0000);
            end
        end
        step(8'h00, 8'h00, 8'h00, 3'd0, 3'd7, 1'b0);
        check("l0_ontime", 16'(on_time), 16'd10);
        check("l0_rd", {8'd0, rd_data}, 16'h0081);

        // Counter saturation
        for (int i = 0; i < 20; i++) step(8'h00, 8'h00, 8'h02, 3'd0, 3'd0, 1'b0);
        step(8'h00, 8'h00, 8'h00, 3'd0, 3'd0, 1'b0);
        check("sat_ontime", 16'(on_time), 16'(CMAX));

        // Reset in the middle of a layer-on interval
        for (int i = 0; i < 5; i++) step(8'h00, 8'h00, 8'h08, 3'd0, 3'd7, 1'b0);
        do_reset();
        step(8'h00, 8'h00, 8'h00, 3'd0, 3'd7, 1'b0);
        check("postrst_ontime", 16'(on_time), 16'h0000);

        // Full frame: eight layers, one column each
        for (int i = 0; i < 8; i++) begin
            step(dat[i], 8'h80, 8'h00, 3'd0, 3'd0, 1'b0);
            step(dat[i], 8'h00, 8'h00, 3'd0, 3'd0, 1'b0);
            step(8'h00, 8'h00, 8'h80 >> i, 3'd0, 3'd0, 1'b0);
            check($sformatf("frame_commit%0d", i), {15'd0, layer_commit}, 16'h0001);
            check($sformatf("frame_idx%0d", i), {13'd0, layer_idx}, 16'(7 - i));
            check($sformatf("frame_done%0d", i), {15'd0, frame_done}, (i == 7) ? 16'h0001 : 16'h0000);
            step(8'h00, 8'h00, 8'h00, 3'd0, 3'd0, 1'b0);
            check($sformatf("frame_done_after%0d", i), {15'd0, frame_done}, 16'h0000);
        end
        for (int i = 0; i < 8; i++) begin
            step(8'h00, 8'h00, 8'h00, 3'(7 - i), 3'd7, 1'b0);
            check($sformatf("frame_rd%0d", i), {8'd0, rd_data}, {8'd0, dat[i]});
        end

        // Random traffic against the model
        do_reset();
        ly_r = 8'h00;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                r = $urandom_range(0, 9);
                if (r < 5)      ly_r = 8'h00;
                else if (r < 9) ly_r = 8'h01 << $urandom_range(0, 7);
                else            ly_r = 8'($urandom);
            end
            r = $urandom_range(0, 9);
            if (r < 6)      lt_r = 8'h00;
            else if (r < 9) lt_r = 8'h01 << $urandom_range(0, 7);
            else            lt_r = 8'($urandom);
            step(8'($urandom), lt_r, ly_r, 3'($urandom), 3'($urandom), ($urandom_range(0, 15) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
